dcache_ctrl: RTL and testbench

- Direct-mapped data-cache controller sitting directly upstream of the cache data/tag array (256 lines x 16 B, 20-bit tag, V and D per line).
- Accepts CPU load/store requests and performs tag lookup against the array's synchronous read output.
- Drives the array's hit-write and refill-write controls.
- Sequences dirty-victim write-back and line refill over a simple request/ready memory bus.

---
 rtl/dcache_ctrl_pkg.sv | 49 ++++
 rtl/dcache_refill_buf.sv | 57 +++++
 rtl/dcache_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped data-cache controller.
// Contents: array geometry constants, controller state encoding,
// address field-slice helpers and the line word-select / byte-merge helpers.
package dcache_ctrl_pkg;

  localparam int TAG_W  = 20;
  localparam int IDX_W  = 8;
  localparam int OFF_W  = 4;
  localparam int LINE_W = 128;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_MISS      = 3'd2,
    S_REPLACE   = 3'd3,
    S_REFILL    = 3'd4,
    S_REFILL_WR = 3'd5
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:12];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[11:4];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [31:0] a);
    return a[3:0];
  endfunction

  // Word sel (0..3) of a 128-bit line; word 0 sits in the low bits.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [1:0]        sel);
    return line[{sel, 5'd0} +: 32];
  endfunction

  // Bytes whose strobe is set take new_w, the rest keep old_w.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = strb[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_refill_buf.sv
// Refill line buffer: collects the four 32-bit return beats of a line fill.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   clr_i               clear buffer and beat counter (new request accepted)
//   cap_i, cap_data_i   store one return beat at the current counter slot
//   merge_*_i           store data byte-merged into word merge_sel_i
//   line_o              raw buffered line
//   merged_o            line with store bytes merged (when merge_en_i)
module dcache_refill_buf
  import dcache_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              cap_i,
  input  logic [31:0]       cap_data_i,
  input  logic              merge_en_i,
  input  logic [1:0]        merge_sel_i,
  input  logic [3:0]        merge_strb_i,
  input  logic [31:0]       merge_data_i,
  output logic [LINE_W-1:0] line_o,
  output logic [LINE_W-1:0] merged_o
);

  logic [3:0][31:0] line_q;
  logic [1:0]       cnt_q;

  // Beat capture; the counter wraps so extra beats overwrite from word 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
      cnt_q  <= 2'd0;
    end else if (clr_i) begin
      line_q <= '0;
      cnt_q  <= 2'd0;
    end else if (cap_i) begin
      line_q[cnt_q] <= cap_data_i;
      cnt_q         <= cnt_q + 2'd1;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign line_o = line_q;

  // Store-miss merge of the requested word into the refilled line.
  always_comb begin
    merged_o = line_q;
    if (merge_en_i) begin
      merged_o[{merge_sel_i, 5'd0} +: 32] =
        byte_merge(line_q[merge_sel_i], merge_data_i, merge_strb_i);
    end else begin
      merged_o = line_q;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped data-cache controller (256 lines x 16 B).
// Ports:
//   CPU side   : valid/op/addr/wstrb/wdata in, addr_ok/data_ok/rdata out
//   Array side : cm_* outputs drive index/offset and hit/refill writes,
//                cm_v/cm_rtag/cm_rdata/cm_D are the array's synchronous read
//   Memory side: rd_req/rd_addr/rd_rdy line read, ret_* return beats,
//                wr_req/wr_addr/wr_data/wr_rdy dirty-victim write-back
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic              op,
  input  logic [31:0]       addr,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic [TAG_W-1:0]  cm_wtag,
  output logic [IDX_W-1:0]  cm_index,
  output logic [OFF_W-1:0]  cm_offset,
  output logic              cm_hit,
  output logic              cm_refill,
  output logic [3:0]        cm_wstrb,
  output logic [31:0]       cm_wdata,
  output logic [LINE_W-1:0] cm_refill_data,
  output logic              cm_set_D,
  input  logic              cm_v,
  input  logic [TAG_W-1:0]  cm_rtag,
  input  logic [LINE_W-1:0] cm_rdata,
  input  logic              cm_D,
  output logic              rd_req,
  output logic [31:0]       rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data,
  output logic              wr_req,
  output logic [31:0]       wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy
);

  state_e            state_q;
  logic              op_q;
  logic [31:0]       addr_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       wdata_q;
  logic [TAG_W-1:0]  vtag_q;
  logic [LINE_W-1:0] vline_q;
  logic              vdirty_q;

  logic              lookup_hit;
  logic              accept;
  logic              beat_cap;
  logic [LINE_W-1:0] buf_line;
  logic [LINE_W-1:0] buf_merged;

  assign lookup_hit = cm_v && (cm_rtag == addr_tag(addr_q));
  assign accept     = (state_q == S_IDLE) && valid;
  assign beat_cap   = (state_q == S_REFILL) && ret_valid;

  dcache_refill_buf u_refill_buf (
    .clk_i        (clk),
    .rst_ni       (resetn),
    .clr_i        (accept),
    .cap_i        (beat_cap),
    .cap_data_i   (ret_data),
    .merge_en_i   (op_q),
    .merge_sel_i  (addr_q[3:2]),
    .merge_strb_i (wstrb_q),
    .merge_data_i (wdata_q),
    .line_o       (buf_line),
    .merged_o     (buf_merged)
  );

  // Controller FSM plus request and victim latches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= 32'd0;
      wstrb_q  <= 4'd0;
      wdata_q  <= 32'd0;
      vtag_q   <= {TAG_W{1'b0}};
      vline_q  <= {LINE_W{1'b0}};
      vdirty_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            op_q    <= op;
            addr_q  <= addr;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (lookup_hit) begin
            state_q <= S_IDLE;
          end else begin
            vtag_q   <= cm_rtag;
            vline_q  <= cm_rdata;
            vdirty_q <= cm_v & cm_D;
            state_q  <= S_MISS;
          end
        end
        S_MISS: begin
          // Clean victims skip the write-back entirely.
          if (!vdirty_q || wr_rdy) begin
            state_q <= S_REPLACE;
          end
        end
        S_REPLACE: begin
          if (rd_rdy) begin
            state_q <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (ret_valid && ret_last) begin
            state_q <= S_REFILL_WR;
          end
        end
        S_REFILL_WR: state_q <= S_IDLE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode; everything is low unless the current state drives it.
  always_comb begin
    addr_ok        = 1'b0;
    data_ok        = 1'b0;
    rdata          = 32'd0;
    cm_wtag        = {TAG_W{1'b0}};
    cm_index       = addr_idx(addr_q);
    cm_offset      = addr_off(addr_q);
    cm_hit         = 1'b0;
    cm_refill      = 1'b0;
    cm_wstrb       = 4'd0;
    cm_wdata       = 32'd0;
    cm_refill_data = {LINE_W{1'b0}};
    cm_set_D       = 1'b0;
    rd_req         = 1'b0;
    rd_addr        = 32'd0;
    wr_req         = 1'b0;
    wr_addr        = 32'd0;
    wr_data        = {LINE_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        addr_ok = valid;
        // Index straight from the CPU so the array read lands in LOOKUP.
        if (valid) begin
          cm_index  = addr_idx(addr);
          cm_offset = addr_off(addr);
        end else begin
          cm_index  = {IDX_W{1'b0}};
          cm_offset = {OFF_W{1'b0}};
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          data_ok = 1'b1;
          if (op_q) begin
            cm_hit   = 1'b1;
            cm_wstrb = wstrb_q;
            cm_wdata = wdata_q;
            cm_set_D = 1'b1;
          end else begin
            rdata = line_word(cm_rdata, addr_q[3:2]);
          end
        end else begin
          data_ok = 1'b0;
        end
      end
      S_MISS: begin
        if (vdirty_q) begin
          wr_req  = 1'b1;
          wr_addr = {vtag_q, addr_idx(addr_q), 4'd0};
          wr_data = vline_q;
        end else begin
          wr_req = 1'b0;
        end
      end
      S_REPLACE: begin
        rd_req  = 1'b1;
        rd_addr = {addr_q[31:4], 4'd0};
      end
      S_REFILL: begin
        rd_req = 1'b0;
      end
      S_REFILL_WR: begin
        cm_refill      = 1'b1;
        cm_wstrb       = 4'b1111;
        cm_wtag        = addr_tag(addr_q);
        cm_refill_data = buf_merged;
        cm_set_D       = op_q;
        data_ok        = 1'b1;
        if (op_q) begin
          rdata = 32'd0;
        end else begin
          rdata = line_word(buf_line, addr_q[3:2]);
        end
      end
      default: begin
        addr_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk, resetn, valid, op;
  logic [31:0]  addr, wdata, rdata;
  logic [3:0]   wstrb;
  logic         addr_ok, data_ok;
  logic [19:0]  cm_wtag, cm_rtag;
  logic [7:0]   cm_index;
  logic [3:0]   cm_offset, cm_wstrb;
  logic         cm_hit, cm_refill, cm_set_D, cm_v, cm_D;
  logic [31:0]  cm_wdata;
  logic [127:0] cm_refill_data, cm_rdata, wr_data;
  logic         rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy;
  logic [31:0]  rd_addr, ret_data, wr_addr;

  dcache_ctrl dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .cm_wtag(cm_wtag), .cm_index(cm_index),
    .cm_offset(cm_offset), .cm_hit(cm_hit), .cm_refill(cm_refill),
    .cm_wstrb(cm_wstrb), .cm_wdata(cm_wdata), .cm_refill_data(cm_refill_data),
    .cm_set_D(cm_set_D), .cm_v(cm_v), .cm_rtag(cm_rtag), .cm_rdata(cm_rdata),
    .cm_D(cm_D), .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  logic any_out;
  assign any_out = |{addr_ok, data_ok, rdata, cm_wtag, cm_index, cm_offset,
                     cm_hit, cm_refill, cm_wstrb, cm_wdata, cm_refill_data,
                     cm_set_D, rd_req, rd_addr, wr_req, wr_addr, wr_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory contents and CPU-visible reference ----------------
  logic [31:0]  preset  [int unsigned];  // word addr -> initial memory word
  logic [31:0]  ref_mem [int unsigned];  // word addr -> CPU-visible word
  logic [127:0] mem_wb  [int unsigned];  // line addr -> written-back line

  function automatic logic [31:0] init_word(input int unsigned wa);
    if (preset.exists(wa)) return preset[wa];
    return (wa * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_word((a >> 4) * 4 + w);
    return l;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    if (mem_wb.exists(a >> 4)) return mem_wb[a >> 4];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = init_word((a >> 4) * 4 + w);
    return l;
  endfunction

  // Abstract direct-mapped cache state: which line each index holds.
  logic        val_m   [256];
  logic [19:0] tag_m   [256];
  logic        dirty_m [256];

  typedef struct {
    logic         op;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [31:0]  wdata;
    logic         hit;
    logic         dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_line;
    logic [31:0]  exp_rdata;
    logic [127:0] exp_line;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t sb_q[$];

  function automatic void model_accept(input logic o, input logic [31:0] a,
                                       input logic [3:0] s, input logic [31:0] d,
                                       output exp_t e);
    int unsigned idx, wa;
    logic [31:0] w;
    idx = a[11:4];
    wa  = a >> 2;
    e.op = o; e.addr = a; e.wstrb = s; e.wdata = d; e.acc_cyc = 0;
    e.hit   = val_m[idx] && (tag_m[idx] == a[31:12]);
    e.dirty = !e.hit && val_m[idx] && dirty_m[idx];
    e.victim_addr = {tag_m[idx], a[11:4], 4'h0};
    e.victim_line = ref_line(e.victim_addr);
    e.exp_rdata = ref_word(wa);
    if (o) begin
      w = ref_word(wa);
      for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
      ref_mem[wa] = w;
    end
    e.exp_line   = ref_line(a);
    dirty_m[idx] = e.hit ? (dirty_m[idx] | o) : o;
    val_m[idx]   = 1'b1;
    tag_m[idx]   = a[31:12];
  endfunction

  // ---------------- cache array model (synchronous read) ----------------
  logic        arr_v   [256];
  logic        arr_d   [256];
  logic [19:0] arr_tag [256];
  logic [127:0] arr_data [256];

  initial begin
    logic [7:0] a_idx; logic [3:0] a_off, a_strb; logic a_hit, a_ref, a_setd;
    logic [31:0] a_wd, w; logic [19:0] a_tag; logic [127:0] a_line;
    for (int i = 0; i < 256; i++) begin
      arr_v[i] = 1'b0; arr_d[i] = 1'b0; arr_tag[i] = 20'h0; arr_data[i] = 128'h0;
      val_m[i] = 1'b0; dirty_m[i] = 1'b0; tag_m[i] = 20'h0;
    end
    cm_v = 1'b0; cm_D = 1'b0; cm_rtag = 20'h0; cm_rdata = 128'h0;
    forever begin
      @(negedge clk);
      a_idx = cm_index; a_off = cm_offset; a_hit = cm_hit; a_ref = cm_refill;
      a_setd = cm_set_D; a_strb = cm_wstrb; a_wd = cm_wdata; a_tag = cm_wtag;
      a_line = cm_refill_data;
      @(posedge clk); #1;
      if (a_ref) begin
        arr_v[a_idx] = 1'b1; arr_tag[a_idx] = a_tag; arr_d[a_idx] = a_setd;
        arr_data[a_idx] = a_line;
      end else if (a_hit) begin
        w = arr_data[a_idx][a_off[3:2]*32 +: 32];
        for (int b = 0; b < 4; b++) if (a_strb[b]) w[b*8 +: 8] = a_wd[b*8 +: 8];
        arr_data[a_idx][a_off[3:2]*32 +: 32] = w;
        arr_d[a_idx] = arr_d[a_idx] | a_setd;
      end
      cm_v = arr_v[a_idx]; cm_D = arr_d[a_idx];
      cm_rtag = arr_tag[a_idx]; cm_rdata = arr_data[a_idx];
    end
  end

  // ---------------- memory bus responder ----------------
  int   abort_beats = -1;
  logic abort_done  = 1'b0;

  initial begin
    logic [127:0] line;
    int nb;
    rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (resetn && wr_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        wr_rdy = 1'b1;
        mem_wb[wr_addr >> 4] = wr_data;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
      end else if (resetn && rd_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        line = mem_line(rd_addr);
        nb = (abort_beats >= 0) ? abort_beats : 4;
        rd_rdy = 1'b1;
        @(posedge clk); #1;
        rd_rdy = 1'b0;
        for (int b = 0; b < nb; b++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          ret_valid = 1'b1; ret_data = line[b*32 +: 32]; ret_last = (b == 3);
          @(posedge clk); #1;
          ret_valid = 1'b0; ret_last = 1'b0;
        end
        if (nb < 4) abort_done = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic manual = 1'b0;
  logic saw_wr = 1'b0;
  logic saw_rd = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        saw_wr = 1'b0; saw_rd = 1'b0;
      end else begin
        chk("hold_rule", (cm_hit | cm_refill | cm_set_D | (|cm_wstrb)) & ~data_ok, 1'b0);
        if (wr_req && wr_rdy && !manual) begin
          if (sb_q.size() == 0) begin
            tests++; fails++; $display("FAIL wr_unexpected: got wr_req expected none");
          end else begin
            chk("wr_expected", sb_q[0].dirty, 1'b1);
            chk("wr_addr", wr_addr, sb_q[0].victim_addr);
            chk("wr_data", wr_data, sb_q[0].victim_line);
            saw_wr = 1'b1;
          end
        end
        if (rd_req && rd_rdy && !manual) begin
          if (sb_q.size() == 0) begin
            tests++; fails++; $display("FAIL rd_unexpected: got rd_req expected none");
          end else begin
            chk("rd_addr", rd_addr, {sb_q[0].addr[31:4], 4'h0});
            chk("rd_after_wr", saw_wr, sb_q[0].dirty);
            saw_rd = 1'b1;
          end
        end
        if (data_ok && !manual) begin
          if (sb_q.size() == 0) begin
            tests++; fails++; $display("FAIL data_ok_unexpected: got data_ok expected none");
          end else begin
            e = sb_q.pop_front();
            chk("cm_index", cm_index, e.addr[11:4]);
            if (e.hit) begin
              chk("hit_latency", cyc, e.acc_cyc + 1);
              chk("hit_no_rd", saw_rd, 1'b0);
              chk("hit_refill", cm_refill, 1'b0);
              if (e.op) begin
                chk("st_cm_hit", cm_hit, 1'b1);
                chk("st_cm_wstrb", cm_wstrb, e.wstrb);
                chk("st_cm_wdata", cm_wdata, e.wdata);
                chk("st_set_D", cm_set_D, 1'b1);
              end else begin
                chk("ld_hit_rdata", rdata, e.exp_rdata);
                chk("ld_cm_hit", cm_hit, 1'b0);
              end
            end else begin
              chk("miss_rd_seen", saw_rd, 1'b1);
              chk("miss_wb_seen", saw_wr, e.dirty);
              chk("refill", cm_refill, 1'b1);
              chk("refill_hit", cm_hit, 1'b0);
              chk("refill_wstrb", cm_wstrb, 4'b1111);
              chk("refill_wtag", cm_wtag, e.addr[31:12]);
              chk("refill_data", cm_refill_data, e.exp_line);
              chk("refill_set_D", cm_set_D, e.op);
              if (!e.op) chk("ld_miss_rdata", rdata, e.exp_rdata);
            end
            saw_wr = 1'b0; saw_rd = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- CPU driver ----------------
  task automatic do_req(input logic o, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    exp_t e;
    int n = 0;
    @(posedge clk); #1;
    valid = 1'b1; op = o; addr = a; wstrb = s; wdata = d;
    forever begin
      @(negedge clk);
      if (addr_ok) break;
      n++;
      if (n > 300) break;
    end
    if (!addr_ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no addr_ok expected addr_ok for %h", a);
    end else begin
      model_accept(o, a, s, d, e);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sb_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    resetn = 1'b0; valid = 1'b0; op = 1'b0; addr = 32'h0; wstrb = 4'h0; wdata = 32'h0;
    preset[32'h1230 >> 2] = 32'h11;
    preset[32'h1234 >> 2] = 32'h22;
    preset[32'h1238 >> 2] = 32'h33;
    preset[32'h123C >> 2] = 32'h44;
    preset[32'h3238 >> 2] = 32'h01020304;

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", any_out, 1'b0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", any_out, 1'b0);

    // Directed sequence
    do_req(1'b0, 32'h00001234, 4'h0, 32'h0);         // clean load miss -> 0x22
    do_req(1'b0, 32'h00001238, 4'h0, 32'h0);         // load hit -> 0x33
    do_req(1'b1, 32'h00001230, 4'b0011, 32'hAABBCCDD); // store hit
    do_req(1'b0, 32'h00001230, 4'h0, 32'h0);         // -> 0x0000CCDD
    do_req(1'b0, 32'h00002230, 4'h0, 32'h0);         // dirty eviction
    do_req(1'b1, 32'h00003238, 4'b1000, 32'h5A000000); // partial store miss
    do_req(1'b0, 32'h00003238, 4'h0, 32'h0);         // -> 0x5A020304
    wait_drain();
    chk("store_merge_word", ref_word(32'h3238 >> 2), 32'h5A020304);

    // Reset in the middle of a refill
    manual = 1'b1;
    abort_beats = 2;
    @(posedge clk); #1;
    valid = 1'b1; op = 1'b0; addr = 32'h00004560;
    @(negedge clk);
    chk("rst_accept", addr_ok, 1'b1);
    @(posedge clk); #1;
    valid = 1'b0;
    n = 0;
    while (!rd_req && n < 50) begin @(negedge clk); n++; end
    chk("rst_rd_addr", rd_addr, 32'h00004560);
    n = 0;
    while (!abort_done && n < 50) begin @(negedge clk); n++; end
    chk("rst_beats_sent", abort_done, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_outputs", any_out, 1'b0);
    repeat (2) @(posedge clk); #1;
    chk("rst_hold_outputs", any_out, 1'b0);
    resetn = 1'b1;
    abort_beats = -1;
    manual = 1'b0;
    @(negedge clk);
    chk("rst_release_outputs", any_out, 1'b0);
    do_req(1'b0, 32'h00004560, 4'h0, 32'h0);         // fresh miss, same rd_addr
    wait_drain();

    // Randomized traffic over a few conflicting lines
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = {20'($urandom_range(16, 19)), 8'($urandom_range(64, 67)), 4'($urandom_range(0, 15))};
      do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
